// File: rtl/ex_mem_register_if.sv
// ---------------------------------------------------------------------------
// ExMemRegisterIf
// Handshake bus between the EX stage, the EX/MEM pipeline register and the
// MEM stage.
//   in_*  : EX-side valid/ready handshake plus the EX results and controls
//   out_* : MEM-side valid/ready handshake plus the registered copy for MEM
// The register itself connects through the slave modport; the environment
// (EX driver on one side, MEM consumer on the other) uses the master modport.
// ---------------------------------------------------------------------------
interface ex_mem_register_if;

    // EX side
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_alu_result;
    logic [63:0] in_write_data;
    logic [63:0] in_branch_target;
    logic        in_zero;
    logic        in_not_zero;
    logic        in_MemWrite;
    logic        in_MemRead;
    logic        in_Branch;
    logic        in_Uncondbranch;
    logic        in_MemtoReg;
    logic        in_RegWrite;
    logic [4:0]  in_rd;

    // MEM side
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_alu_result;
    logic [63:0] out_write_data;
    logic [63:0] out_branch_target;
    logic        out_zero;
    logic        out_not_zero;
    logic        out_MemWrite;
    logic        out_MemRead;
    logic        out_Branch;
    logic        out_Uncondbranch;
    logic        out_MemtoReg;
    logic        out_RegWrite;
    logic [4:0]  out_rd;

    // The pipeline register: consumes EX results, produces the MEM copy
    modport slave (
        input  in_valid, in_alu_result, in_write_data, in_branch_target,
               in_zero, in_not_zero, in_MemWrite, in_MemRead, in_Branch,
               in_Uncondbranch, in_MemtoReg, in_RegWrite, in_rd,
               out_ready,
        output in_ready,
               out_valid, out_alu_result, out_write_data, out_branch_target,
               out_zero, out_not_zero, out_MemWrite, out_MemRead, out_Branch,
               out_Uncondbranch, out_MemtoReg, out_RegWrite, out_rd
    );

    // The surrounding pipeline: drives EX results and MEM's ready
    modport master (
        output in_valid, in_alu_result, in_write_data, in_branch_target,
               in_zero, in_not_zero, in_MemWrite, in_MemRead, in_Branch,
               in_Uncondbranch, in_MemtoReg, in_RegWrite, in_rd,
               out_ready,
        input  in_ready,
               out_valid, out_alu_result, out_write_data, out_branch_target,
               out_zero, out_not_zero, out_MemWrite, out_MemRead, out_Branch,
               out_Uncondbranch, out_MemtoReg, out_RegWrite, out_rd
    );

endinterface

// File: rtl/ex_mem_register.sv
// ---------------------------------------------------------------------------
// ex_mem_register
// EX/MEM pipeline register built as a two-entry skid buffer. The main entry
// drives the MEM-side outputs; the skid entry catches one instruction that EX
// handed over while MEM was stalled, so in_ready can come straight from the
// state register instead of combinationally from out_ready.
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   flush       squash held and incoming entries (taken branch)
//   bus         ex_mem_register_if.slave - EX/MEM handshakes and payload
//   stall_count cycles in which MEM held a valid entry but was not ready
// ---------------------------------------------------------------------------
module ex_mem_register (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      flush,
    ex_mem_register_if.slave          bus,
    output logic [31:0]               stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    typedef struct packed {
        logic [63:0] aluResult;
        logic [63:0] writeData;
        logic [63:0] branchTarget;
        logic        zero;
        logic        notZero;
        logic        memWrite;
        logic        memRead;
        logic        branch;
        logic        uncondBranch;
        logic        memtoReg;
        logic        regWrite;
        logic [4:0]  rd;
    } entry_t;

    state_t      state_q;
    entry_t      main_q;
    entry_t      skid_q;
    logic [31:0] stallCount_q;
    logic [31:0] stallCount_d;
    entry_t      inEntry;
    logic        outValid;

    // Gather the EX-side payload into one entry so main/skid moves are whole
    assign inEntry = '{
        aluResult:    bus.in_alu_result,
        writeData:    bus.in_write_data,
        branchTarget: bus.in_branch_target,
        zero:         bus.in_zero,
        notZero:      bus.in_not_zero,
        memWrite:     bus.in_MemWrite,
        memRead:      bus.in_MemRead,
        branch:       bus.in_Branch,
        uncondBranch: bus.in_Uncondbranch,
        memtoReg:     bus.in_MemtoReg,
        regWrite:     bus.in_RegWrite,
        rd:           bus.in_rd
    };

    // Handshake flags are pure functions of the state register
    assign outValid     = (state_q != EMPTY);
    assign bus.out_valid = outValid;
    assign bus.in_ready  = (state_q != SKID);

    // Buffer control. Flush only returns to EMPTY; the main entry's data is
    // left in place so the data outputs keep their last value, while the
    // side-effecting controls are gated below. In SKID the input is ignored
    // because in_ready is already low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (bus.in_valid) begin
                        main_q  <= inEntry;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        if (bus.in_valid) begin
                            main_q <= inEntry;
                        end else begin
                            state_q <= EMPTY;
                        end
                    end else if (bus.in_valid) begin
                        skid_q  <= inEntry;
                        state_q <= SKID;
                    end
                end
                SKID: begin
                    if (bus.out_ready) begin
                        main_q  <= skid_q;
                        state_q <= FULL;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    // Stall counter wraps naturally and deliberately ignores flush
    always_comb begin
        stallCount_d = stallCount_q;
        if (outValid && !bus.out_ready) begin
            stallCount_d = stallCount_q + 32'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stallCount_q <= '0;
        end else begin
            stallCount_q <= stallCount_d;
        end
    end

    assign stall_count = stallCount_q;

    // Data fields always show the main entry; controls that cause memory or
    // register-file side effects must be low whenever nothing valid is held
    assign bus.out_alu_result    = main_q.aluResult;
    assign bus.out_write_data    = main_q.writeData;
    assign bus.out_branch_target = main_q.branchTarget;
    assign bus.out_zero          = main_q.zero;
    assign bus.out_not_zero      = main_q.notZero;
    assign bus.out_MemtoReg      = main_q.memtoReg;
    assign bus.out_rd            = main_q.rd;
    assign bus.out_MemWrite      = main_q.memWrite     & outValid;
    assign bus.out_MemRead       = main_q.memRead      & outValid;
    assign bus.out_Branch        = main_q.branch       & outValid;
    assign bus.out_Uncondbranch  = main_q.uncondBranch & outValid;
    assign bus.out_RegWrite      = main_q.regWrite     & outValid;

endmodule

// File: doc/ex_mem_register.md
EX_MEM_REGISTER -- requirements
Module: ex_mem_register

Interface
REQ-001 clock  input  1  single clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous active-low reset; asserting it clears state immediately, independent of clock.
REQ-003 flush  input  1  squash all held and incoming entries (taken branch).
REQ-004 in_valid  input  1  EX presents a valid instruction.
REQ-005 in_ready  output  1  register can accept this cycle.
REQ-006 in_alu_result, in_write_data, in_branch_target  input  64 each  EX results.
REQ-007 in_zero, in_not_zero, in_MemWrite, in_MemRead, in_Branch, in_Uncondbranch, in_MemtoReg, in_RegWrite  input  1 each  flags and control.
REQ-008 in_rd  input  5  destination register.
REQ-009 out_valid  output  1  MEM stage holds a valid instruction.
REQ-010 out_ready  input  1  MEM consumes the output this cycle.
REQ-011 out_* (alu_result, write_data, branch_target, zero, not_zero, MemWrite, MemRead, Branch, Uncondbranch, MemtoReg, RegWrite, rd)  output  widths as inputs  registered copy for MEM.
REQ-012 stall_count  output  32  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-013 Block SHALL be a two-entry skid buffer: main register drives out_*; skid register holds one overflow entry.
REQ-014 States SHALL be EMPTY (none held), FULL (main only), SKID (main and skid).
REQ-015 in_ready SHALL be 1 in EMPTY and FULL and 0 in SKID; it SHALL depend only on state, not on out_ready.
REQ-016 out_valid SHALL be 1 in FULL and SKID and 0 in EMPTY.
REQ-017 EMPTY: in_valid=1 -> load main, go FULL; else stay.
REQ-018 FULL, out_ready=1, in_valid=1 -> load main with input, stay FULL.
REQ-019 FULL, out_ready=1, in_valid=0 -> go EMPTY.
REQ-020 FULL, out_ready=0, in_valid=1 -> load skid, go SKID; main unchanged.
REQ-021 FULL, out_ready=0, in_valid=0 -> hold.
REQ-022 SKID, out_ready=1 -> copy skid to main, go FULL; in_valid ignored (in_ready=0).
REQ-023 SKID, out_ready=0 -> hold both entries.
REQ-024 Latency SHALL be one cycle: input accepted at edge N appears on out_* with out_valid=1 after edge N when main is loaded directly.
REQ-025 Entries SHALL leave in acceptance order; no entry dropped or duplicated absent flush.
REQ-026 flush=1 SHALL force next state EMPTY from any state, discard main, skid, and any simultaneous input; flush overrides in_valid and out_ready.
REQ-027 out_MemWrite, out_MemRead, out_Branch, out_Uncondbranch, out_RegWrite SHALL be gated to 0 whenever out_valid=0; data outputs hold last value.
REQ-028 stall_count SHALL increment by 1 each cycle out_valid=1 and out_ready=0, wrap from 0xFFFFFFFF to 0, and be unaffected by flush.

Reset
REQ-029 reset_n=0 SHALL asynchronously set state EMPTY, out_valid=0, all out_* and stall_count to 0, in_ready=1.
REQ-030 Reset mid-operation SHALL discard held entries; first accept after release occurs on first rising edge with reset_n=1 and in_valid=1.

Verification
REQ-031 Reset, then in_valid=1 with alu_result=0x10, out_ready=1 -> next cycle out_valid=1, out_alu_result=0x10, in_ready=1.
REQ-032 Stream A=0x1,B=0x2,C=0x3 with out_ready=0 from cycle 2 -> state SKID holding A(main),B(skid), in_ready=0, C held upstream; then out_ready=1 -> outputs A,B,C in order, none lost.
REQ-033 SKID state, flush=1 with in_valid=1 -> next cycle out_valid=0, out_MemWrite=0, in_ready=1; no entry emerges afterward.
REQ-034 Output valid with out_ready=0 for 5 cycles -> stall_count increases by exactly 5; preload 0xFFFFFFFF plus one stall cycle -> 0.
REQ-035 reset_n pulsed low between edges while FULL -> out_valid=0 immediately, before next clock edge.
REQ-036 EMPTY with in_valid=0 and in_MemWrite=1 -> out_MemWrite stays 0, no state change.
